// File: rtl/pixel_frame_wr_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_frame_wr_ctrl
//
// Writes a raster pixel stream into a two-bank frame buffer in block RAM.
// One bank is filled while the other is offered to a downstream reader. When
// both banks are full, the writer parks in HOLD and drops incoming pixels,
// flagging overflow. It resumes at the next frame boundary once the reader
// has released the bank the writer needs. An optional 2x2 decimation mode
// stores only pixels on even rows and even columns. The mode is latched at
// the first pixel of each frame.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   start_i      : arms the writer (only honoured in IDLE)
//   decim_i      : 0 = full frame, 1 = 2x2 decimation (latched per frame)
//   pixel_i      : incoming pixel data
//   pixel_en_i   : pixel_i valid this cycle (raster order, gaps allowed)
//   rd_done_i    : reader releases the bank it is currently reading
//   ena_o/wea_o  : BRAM port enable / write strobe
//   addra_o      : BRAM write address (bank base + write index)
//   d2mema_o     : BRAM write data
//   wr_bank_o    : bank currently being written
//   rd_bank_o    : bank currently offered to the reader
//   rd_valid_o   : offered read bank holds a complete frame
//   frame_done_o : one-cycle pulse when a frame finishes writing
//   overflow_o   : sticky, pixels arrived while no bank was free
//   busy_o       : controller is not IDLE
//   frame_cnt_o  : completed frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module pixel_frame_wr_ctrl #(
    parameter int PIX_W   = 8,
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540,
    parameter int ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              decim_i,
    input  logic [PIX_W-1:0]  pixel_i,
    input  logic              pixel_en_i,
    input  logic              rd_done_i,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [PIX_W-1:0]  d2mema_o,
    output logic              wr_bank_o,
    output logic              rd_bank_o,
    output logic              rd_valid_o,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              busy_o,
    output logic [7:0]        frame_cnt_o
);

    localparam int COL_W = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    localparam int ROW_W = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;

    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(MAX_ROW * MAX_COL);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(MAX_COL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MAX_ROW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // State and bookkeeping registers
    state_t              state_r,      state_s;
    logic [COL_W-1:0]    col_r,        col_s;
    logic [ROW_W-1:0]    row_r,        row_s;
    logic [ADDR_W-1:0]   widx_r,       widx_s;
    logic                decim_r,      decim_s;
    logic [1:0]          full_r,       full_s;
    logic                wr_bank_r,    wr_bank_s;
    logic                rd_bank_r,    rd_bank_s;
    logic                overflow_r,   overflow_s;
    logic [7:0]          frame_cnt_r,  frame_cnt_s;

    // Registered output stage
    logic                wr_r,         wr_s;
    logic [ADDR_W-1:0]   addra_r,      addra_s;
    logic [PIX_W-1:0]    d2mema_r,     d2mema_s;
    logic                frame_done_r, frame_done_s;
    logic                busy_r;
    logic                rd_valid_r;

    // Decode helpers
    logic                at_origin_s;
    logic                at_last_s;
    logic                rd_release_s;
    logic [1:0]          full_rel_s;
    logic                hold_exit_s;
    logic                writing_s;
    logic                decim_eff_s;
    logic                keep_pix_s;
    logic [ADDR_W-1:0]   bank_base_s;

    // Position decode, reader release and write qualification
    always_comb begin
        at_origin_s  = (col_r == {COL_W{1'b0}}) && (row_r == {ROW_W{1'b0}});
        at_last_s    = (col_r == COL_LAST) && (row_r == ROW_LAST);
        // A release is only meaningful when the offered bank is actually full.
        rd_release_s = rd_done_i && full_r[rd_bank_r];
        full_rel_s   = full_r;
        if (rd_release_s) begin
            full_rel_s[rd_bank_r] = 1'b0;
        end else begin
            full_rel_s = full_r;
        end
        // HOLD at a frame boundary with a free bank is itself a frame start,
        // so a pixel arriving in that same cycle is written, not dropped.
        hold_exit_s  = (state_r == ST_HOLD) && at_origin_s && !full_rel_s[wr_bank_r];
        writing_s    = (state_r == ST_WRITE) || hold_exit_s;
        // The decimation mode of a frame is taken from its first pixel.
        decim_eff_s  = at_origin_s ? decim_i : decim_r;
        keep_pix_s   = !decim_eff_s || (!col_r[0] && !row_r[0]);
        bank_base_s  = wr_bank_r ? FRAME_PIX : {ADDR_W{1'b0}};
    end

    // Next-state, counter, bank and output logic
    always_comb begin
        state_s      = state_r;
        col_s        = col_r;
        row_s        = row_r;
        widx_s       = widx_r;
        decim_s      = decim_r;
        full_s       = full_rel_s;
        wr_bank_s    = wr_bank_r;
        rd_bank_s    = rd_release_s ? ~rd_bank_r : rd_bank_r;
        overflow_s   = overflow_r;
        frame_cnt_s  = frame_cnt_r;
        wr_s         = 1'b0;
        addra_s      = addra_r;
        d2mema_s     = d2mema_r;
        frame_done_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_WRITE;
                    col_s   = {COL_W{1'b0}};
                    row_s   = {ROW_W{1'b0}};
                    widx_s  = {ADDR_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WRITE, ST_HOLD: begin
                if (pixel_en_i) begin
                    // Raster position tracks the input even while dropping.
                    if (col_r == COL_LAST) begin
                        col_s = {COL_W{1'b0}};
                        if (row_r == ROW_LAST) begin
                            row_s = {ROW_W{1'b0}};
                        end else begin
                            row_s = row_r + ROW_W'(1);
                        end
                    end else begin
                        col_s = col_r + COL_W'(1);
                    end

                    if (at_origin_s) begin
                        decim_s = decim_i;
                    end else begin
                        decim_s = decim_r;
                    end

                    if (writing_s) begin
                        if (keep_pix_s) begin
                            wr_s     = 1'b1;
                            addra_s  = bank_base_s + widx_r;
                            d2mema_s = pixel_i;
                            widx_s   = widx_r + ADDR_W'(1);
                        end else begin
                            widx_s   = widx_r;
                        end

                        if (at_last_s) begin
                            frame_done_s      = 1'b1;
                            full_s[wr_bank_r] = 1'b1;
                            wr_bank_s         = ~wr_bank_r;
                            frame_cnt_s       = frame_cnt_r + 8'd1;
                            widx_s            = {ADDR_W{1'b0}};
                            // The release above already counts, so a bank freed
                            // this cycle lets the writer carry straight on.
                            state_s = full_rel_s[~wr_bank_r] ? ST_HOLD : ST_WRITE;
                        end else begin
                            state_s = ST_WRITE;
                        end
                    end else begin
                        overflow_s = 1'b1;
                        state_s    = ST_HOLD;
                    end
                end else if (hold_exit_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = state_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            widx_r       <= {ADDR_W{1'b0}};
            decim_r      <= 1'b0;
            full_r       <= 2'b00;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            overflow_r   <= 1'b0;
            frame_cnt_r  <= 8'd0;
            wr_r         <= 1'b0;
            addra_r      <= {ADDR_W{1'b0}};
            d2mema_r     <= {PIX_W{1'b0}};
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            rd_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            col_r        <= col_s;
            row_r        <= row_s;
            widx_r       <= widx_s;
            decim_r      <= decim_s;
            full_r       <= full_s;
            wr_bank_r    <= wr_bank_s;
            rd_bank_r    <= rd_bank_s;
            overflow_r   <= overflow_s;
            frame_cnt_r  <= frame_cnt_s;
            wr_r         <= wr_s;
            addra_r      <= addra_s;
            d2mema_r     <= d2mema_s;
            frame_done_r <= frame_done_s;
            busy_r       <= (state_s != ST_IDLE);
            rd_valid_r   <= full_s[rd_bank_s];
        end
    end

    assign ena_o        = wr_r;
    assign wea_o        = wr_r;
    assign addra_o      = addra_r;
    assign d2mema_o     = d2mema_r;
    assign wr_bank_o    = wr_bank_r;
    assign rd_bank_o    = rd_bank_r;
    assign rd_valid_o   = rd_valid_r;
    assign frame_done_o = frame_done_r;
    assign overflow_o   = overflow_r;
    assign busy_o       = busy_r;
    assign frame_cnt_o  = frame_cnt_r;

endmodule

// File: doc/pixel_frame_wr_ctrl.md
PIXEL_FRAME_WR_CTRL -- requirements
Module: pixel_frame_wr_ctrl

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel data width.
REQ-002 SHALL have parameter MAX_ROW, default 540, rows per frame.
REQ-003 SHALL have parameter MAX_COL, default 540, columns per frame.
REQ-004 SHALL have parameter ADDR_W, default 20, BRAM address width (must hold 2*MAX_ROW*MAX_COL).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start_i  input  1  arms writer; effective only in IDLE.
REQ-008 SHALL have port decim_i  input  1  0 full frame, 1 2x2 decimation; sampled at each frame start.
REQ-009 SHALL have port pixel_i  input  PIX_W  incoming pixel.
REQ-010 SHALL have port pixel_en_i  input  1  pixel_i valid this cycle, raster order.
REQ-011 SHALL have port rd_done_i  input  1  consumer releases current read bank.
REQ-012 SHALL have ports ena_o, wea_o  output  1 each  BRAM port enable / write strobe.
REQ-013 SHALL have port addra_o  output  ADDR_W  BRAM write address.
REQ-014 SHALL have port d2mema_o  output  PIX_W  BRAM write data.
REQ-015 SHALL have ports wr_bank_o, rd_bank_o, rd_valid_o  output  1 each  bank being written, bank offered to reader, read bank full.
REQ-016 SHALL have ports frame_done_o  output  1  one-cycle pulse; overflow_o  output  1  sticky; busy_o  output  1  not IDLE.
REQ-017 SHALL have port frame_cnt_o  output  8  completed frames, wraps 255->0.

Function
REQ-018 SHALL implement states IDLE, WRITE, HOLD; all outputs registered.
REQ-019 IDLE: pixels ignored, ena_o=wea_o=0; start_i=1 -> WRITE with input counters 0.
REQ-020 Input col counter SHALL advance on pixel_en_i in WRITE and HOLD, wrap at MAX_COL-1 and advance row; row wraps at MAX_ROW-1 (frame boundary).
REQ-021 Pixel SHALL be written when in WRITE and (decim=0, or col[0]=0 and row[0]=0).
REQ-022 Write latency SHALL be 1 cycle: ena_o=wea_o=1, d2mema_o=pixel_i, addra_o=wr_bank*MAX_ROW*MAX_COL + write index, cycle after pixel_en_i.
REQ-023 Write index SHALL count written pixels only, reset to 0 each frame start.
REQ-024 Last input pixel of a frame in WRITE SHALL pulse frame_done_o (cycle after pixel_en_i), set full[wr_bank], toggle wr_bank_o, increment frame_cnt_o.
REQ-025 After completion, if new wr_bank is full -> HOLD, else remain WRITE.
REQ-026 HOLD: no writes; every pixel_en_i SHALL set overflow_o; exit to WRITE only when full[wr_bank]=0 and input counters at frame boundary (0,0).
REQ-027 rd_valid_o SHALL equal full[rd_bank]; rd_done_i with rd_valid_o=1 clears full[rd_bank] and toggles rd_bank_o; rd_done_i with rd_valid_o=0 ignored.
REQ-028 rd_done_i in same cycle as frame completion SHALL be applied first: freed bank counts as free for REQ-025.
REQ-029 pixel_en_i gaps SHALL stall counters without error.
REQ-030 decim_i changes mid-frame SHALL have no effect until next frame start.

Reset
REQ-031 rst SHALL return to IDLE, clear counters, full flags, overflow_o, frame_cnt_o; all outputs 0 next cycle, including mid-frame.
REQ-032 After reset, a new start_i SHALL be required.

Verification (MAX_ROW=4, MAX_COL=4, ADDR_W=5)
REQ-033 rst=1 two cycles -> all outputs 0, busy_o=0; pixels without start_i -> no wea_o.
REQ-034 start_i, pixels 0..15 back-to-back -> addra 0..15, data 0..15, frame_done_o with 16th write, wr_bank_o=1, rd_valid_o=1, frame_cnt_o=1.
REQ-035 Second frame -> addra 16..31; third frame without rd_done_i -> HOLD, no wea_o, overflow_o=1; rd_done_i mid-frame -> writes resume at next frame start at addra 0.
REQ-036 decim_i=1, pixels 0..15 -> 4 writes, addra 0..3, data 0,2,8,10; frame_done_o after pixel 15.
REQ-037 rd_done_i coincident with second frame's last pixel -> no HOLD, third frame written at addra 0, overflow_o=0.
REQ-038 rst asserted after pixel 7 -> outputs 0; restart writes pixel 0 at addra 0, frame_cnt_o=0.
